// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the tx_arbiter slice.
//   tx_arb_state_t : arbiter FSM state (IDLE, HDR, BURST)
//   TX_ARB_HDR_TAG : upper nibble of the per-frame header byte
//   TX_ARB_CNT_W   : width of the per-grant payload byte counter
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BURST = 2'd2
  } tx_arb_state_t;

  localparam logic [3:0]  TX_ARB_HDR_TAG = 4'hA;
  localparam int unsigned TX_ARB_CNT_W   = 8;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : index where the search starts (searches upward, wrapping)
//   idx   : first requesting index at or after ptr
//   found : at least one request bit is set
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [IdxW-1:0]    idx,
  output logic               found
);

  always_comb begin
    int unsigned c;
    c     = 0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      c = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IdxW'(c);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: packet-granular round-robin arbiter sharing one UART transmitter
// between NUM_REQ byte-stream requesters. Presents a TX-queue style interface.
// The grant is held until the granted requester's frame ends (last byte acked)
// or MAX_BURST bytes have been acked, so frames never interleave.
// Optional feature macro: TX_ARB_HEADER_EN -- emits a header byte
// {TX_ARB_HDR_TAG, grant} before each burst.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req_valid    : per-requester byte available
//   i_req_data     : per-requester byte, requester r at [8r+7:8r]
//   i_req_last     : per-requester end-of-frame flag
//   o_req_ack      : per-requester one-cycle consume pulse (combinational)
//   o_data         : byte presented to the transmitter
//   o_txq_empty    : no byte available
//   i_deq_txq      : transmitter consumes o_data this cycle
//   o_busy         : a grant is held
//   o_grant_id     : granted requester index (held while idle)
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ack,
  output logic [7:0]           o_data,
  output logic                 o_txq_empty,
  input  logic                 i_deq_txq,
  output logic                 o_busy,
  output logic [IdxW-1:0]      o_grant_id
);

  localparam logic [TX_ARB_CNT_W-1:0] CntMax  = TX_ARB_CNT_W'(MAX_BURST - 1);
  localparam logic [IdxW-1:0]         LastIdx = IdxW'(NUM_REQ - 1);

  tx_arb_state_t           state_q, state_d;
  logic [IdxW-1:0]         grant_q, grant_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [TX_ARB_CNT_W-1:0] count_q, count_d;
  logic [IdxW-1:0]         pick_idx;
  logic                    pick_found;
  logic                    grant_valid;
  logic                    grant_last;
  logic [7:0]              grant_data;

  assign grant_valid = i_req_valid[grant_q];
  assign grant_last  = i_req_last[grant_q];
  assign grant_data  = i_req_data[{grant_q, 3'b000} +: 8];

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req  (i_req_valid),
    .ptr  (rr_ptr_q),
    .idx  (pick_idx),
    .found(pick_found)
  );

  always_comb begin
    o_data      = '0;
    o_txq_empty = 1'b1;
    o_req_ack   = '0;
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          count_d = '0;
`ifdef TX_ARB_HEADER_EN
          state_d = HDR;
`else
          state_d = BURST;
`endif
        end
      end
`ifdef TX_ARB_HEADER_EN
      HDR: begin
        o_data      = {TX_ARB_HDR_TAG, 4'(grant_q)};
        o_txq_empty = 1'b0;
        // Header consumption acks nobody and is not counted.
        if (i_deq_txq) state_d = BURST;
      end
`endif
      BURST: begin
        o_data      = grant_data;
        o_txq_empty = !grant_valid;
        // A deq while the granted requester is stalled is ignored.
        if (i_deq_txq && grant_valid) begin
          o_req_ack[grant_q] = 1'b1;
          count_d            = count_q + 1'b1;
          if (grant_last || count_q == CntMax) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_busy     = (state_q != IDLE);
  assign o_grant_id = grant_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized self-checking bench for tx_arbiter against a behavioural model.
module tb_tx_arbiter;

  localparam int NumReq   = 4;
  localparam int MaxBurst = 4;
  localparam int IdxW     = $clog2(NumReq);
  localparam int NCycles  = 3000;
  localparam int MIdle    = 0;
  localparam int MHdr     = 1;
  localparam int MBurst   = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic [NumReq-1:0]    i_req_valid;
  logic [NumReq*8-1:0]  i_req_data;
  logic [NumReq-1:0]    i_req_last;
  logic [NumReq-1:0]    o_req_ack;
  logic [7:0]           o_data;
  logic                 o_txq_empty;
  logic                 i_deq_txq;
  logic                 o_busy;
  logic [IdxW-1:0]      o_grant_id;

  always #5 i_clk = ~i_clk;

  tx_arbiter #(
    .NUM_REQ  (NumReq),
    .MAX_BURST(MaxBurst)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req_valid(i_req_valid),
    .i_req_data (i_req_data),
    .i_req_last (i_req_last),
    .o_req_ack  (o_req_ack),
    .o_data     (o_data),
    .o_txq_empty(o_txq_empty),
    .i_deq_txq  (i_deq_txq),
    .o_busy     (o_busy),
    .o_grant_id (o_grant_id)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Requester-side stimulus: per-requester byte queues, presentation and stall state.
  logic [7:0] q_data[NumReq][$];
  bit         q_last[NumReq][$];
  bit         pres[NumReq];
  int         hold[NumReq];
  int         seq[NumReq];
  bit [NumReq-1:0] en_mask;

  // Reference model: grant owner, bytes acked in this grant, round-robin start.
  int m_state, m_grant, m_count, m_ptr;
  int total_acks = 0;
  bit did_rst    = 0;

  function automatic int rr_first(input logic [NumReq-1:0] v, input int ptr);
    for (int k = 0; k < NumReq; k++) if (v[(ptr + k) % NumReq]) return (ptr + k) % NumReq;
    return -1;
  endfunction

  task automatic refill(input int r);
    int len;
    bit term;
    len  = $urandom_range(1, 7);
    term = ($urandom_range(0, 4) != 0);
    for (int i = 0; i < len; i++) begin
      q_data[r].push_back(8'(r * 64 + (seq[r] % 64)));
      q_last[r].push_back(term && (i == len - 1));
      seq[r]++;
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_grant = 0;
    m_count = 0;
    m_ptr   = 0;
  endtask

  initial begin
    logic [7:0]        exp_data;
    logic              exp_empty;
    logic [NumReq-1:0] exp_ack;
    int                p;

    i_rst_n     = 1'b0;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    i_deq_txq   = 1'b0;
    for (int r = 0; r < NumReq; r++) begin
      pres[r] = 0;
      hold[r] = 0;
      seq[r]  = 0;
    end
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_empty", 32'(o_txq_empty), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_grant", 32'(o_grant_id), 32'd0);
    check("rst_ack", 32'(o_req_ack), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    i_rst_n = 1'b1;

    for (int cyc = 0; cyc < NCycles; cyc++) begin
      @(posedge i_clk);
      #1;
      // Early phase: only req0 and req2 compete; later all four.
      en_mask = (cyc < 800) ? 4'b0101 : 4'b1111;
      for (int r = 0; r < NumReq; r++) begin
        if (q_data[r].size() < 2) refill(r);
        if (hold[r] > 0) hold[r]--;
        if (!pres[r] && en_mask[r] && hold[r] == 0 && $urandom_range(0, 3) != 0) pres[r] = 1;
        i_req_valid[r] = pres[r];
        if (pres[r]) begin
          i_req_data[r*8 +: 8] = q_data[r][0];
          i_req_last[r]        = q_last[r][0];
        end else begin
          i_req_data[r*8 +: 8] = 8'($urandom);
          i_req_last[r]        = 1'($urandom);
        end
      end
      i_deq_txq = ($urandom_range(0, 9) < 7);

      if (!did_rst && cyc > 1200 && m_state == MBurst && m_count == 2) begin
        did_rst = 1;
        i_rst_n = 1'b0;
        #1;
        check("midrst_empty", 32'(o_txq_empty), 32'd1);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_grant", 32'(o_grant_id), 32'd0);
        check("midrst_ack", 32'(o_req_ack), 32'd0);
        model_reset();
        i_rst_n = 1'b1;
        #1;
      end else begin
        #2;
      end

      // Expected outputs for this cycle.
      exp_data  = 8'h00;
      exp_empty = 1'b1;
      exp_ack   = '0;
      if (m_state == MHdr) begin
        exp_data  = {4'hA, 4'(m_grant)};
        exp_empty = 1'b0;
      end else if (m_state == MBurst) begin
        exp_data  = i_req_data[m_grant*8 +: 8];
        exp_empty = !i_req_valid[m_grant];
        if (i_deq_txq && i_req_valid[m_grant]) exp_ack[m_grant] = 1'b1;
      end
      check("empty", 32'(o_txq_empty), 32'(exp_empty));
      check("data", 32'(o_data), 32'(exp_data));
      check("ack", 32'(o_req_ack), 32'(exp_ack));
      check("busy", 32'(o_busy), 32'(m_state != MIdle));
      check("grant", 32'(o_grant_id), 32'(m_grant));

      // Advance model and requesters to the next cycle.
      if (m_state == MIdle) begin
        p = rr_first(i_req_valid, m_ptr);
        if (p >= 0) begin
          m_grant = p;
          m_count = 0;
`ifdef TX_ARB_HEADER_EN
          m_state = MHdr;
`else
          m_state = MBurst;
`endif
        end
      end else if (m_state == MHdr) begin
        if (i_deq_txq) m_state = MBurst;
      end else if (exp_ack != 0) begin
        m_count++;
        total_acks++;
        if (q_last[m_grant][0] || m_count == MaxBurst) begin
          m_state = MIdle;
          m_ptr   = (m_grant + 1) % NumReq;
        end
        void'(q_data[m_grant].pop_front());
        void'(q_last[m_grant].pop_front());
        pres[m_grant] = 0;
        if ($urandom_range(0, 7) == 0) hold[m_grant] = 10;
      end
    end

    check("traffic_seen", 32'(total_acks > 200), 32'd1);
    check("reset_hit", 32'(did_rst), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Packet-granular round-robin arbiter that shares the single UART `transmitter` between `NUM_REQ` byte-stream requesters. It sits in the position of the TX queue: it presents a queue-style interface (`o_data`, `o_txq_empty`, `i_deq_txq`) to `transmitter`. It locks the grant to one requester until that requester's frame ends or the `MAX_BURST` limit is reached, so bytes from different sources never interleave mid-frame.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `MAX_BURST`, default 16: maximum payload bytes per grant, 1..256.
- `i_clk` input 1: clock.
- `i_rst_n` input 1: asynchronous, active-low reset.
- `i_req_valid` input NUM_REQ: requester r has a byte available.
- `i_req_data` input NUM_REQ*8: byte of requester r is at bits [8r+7:8r].
- `i_req_last` input NUM_REQ: the current byte of requester r ends its frame.
- `o_req_ack` output NUM_REQ: one-cycle pulse; the current byte of requester r was consumed.
- `o_data` output 8: byte presented to the transmitter.
- `o_txq_empty` output 1: no byte available; drives the transmitter's `i_txq_empty`.
- `i_deq_txq` input 1: the transmitter consumes `o_data` this cycle.
- `o_busy` output 1: a grant is held (state is not IDLE).
- `o_grant_id` output $clog2(NUM_REQ): index of the granted requester; holds its last value while IDLE.

## Operation
- Requester contract: `data` and `last` stay stable while `valid` is high and until `ack`. `valid` may drop only after an `ack`.
- FSM states: IDLE, HDR (present only with the macro), BURST.
- IDLE
  - `o_txq_empty`=1.
  - If any `i_req_valid` bit is set, the arbiter picks the first set bit at or after `r_rr_ptr`, searching upward with wrap.
  - It registers `o_grant_id`, clears `r_count`, and moves to BURST (or HDR with the macro).
- BURST
  - `o_data` = data of the granted requester.
  - `o_txq_empty` = !`i_req_valid[grant]`.
  - On `i_deq_txq` && !`o_txq_empty`: pulse `o_req_ack[grant]` and increment `r_count`.
  - If `last` is set, or `r_count`==MAX_BURST-1, go to IDLE and set `r_rr_ptr` = grant+1, wrapping modulo NUM_REQ.
- The granted requester going invalid mid-frame does not release the grant; the arbiter waits.
- `i_deq_txq` while `o_txq_empty`=1 is ignored: no ack, no count, no state change.
- `o_req_ack` is combinational from `i_deq_txq`, state, and `valid`. At most one bit is set per cycle.
- `r_count` is 8 bits, cleared on grant, and never wraps because the release at MAX_BURST-1 happens first.

## Timing
- Reset values: state=IDLE, `r_rr_ptr`=0, `o_grant_id`=0, `r_count`=0. Outputs: `o_txq_empty`=1, `o_busy`=0, `o_req_ack`=0, `o_data`=0.
- Arbitration latency: `valid` seen in IDLE at cycle t gives BURST/HDR and `o_txq_empty`=0 at cycle t+1.
- Back-to-back frames incur one IDLE cycle between release and the next grant.
- `o_data` and `o_txq_empty` change only on clock edges or on requester input changes; the transmitter samples them in the same cycle it asserts `i_deq_txq`.
- A new `valid` in the release cycle does not affect that cycle's decision; it is seen in the following IDLE cycle.
- Asserting `i_rst_n` low mid-frame immediately forces all reset values. The partially sent frame is abandoned and no ack is issued.

## Configuration
- `TX_ARB_HEADER_EN` defined:
  - After a grant, the FSM enters HDR.
  - HDR presents `o_data` = {TX_ARB_HDR_TAG[3:0], 4'(grant)} with `o_txq_empty`=0.
  - `i_deq_txq` in HDR moves to BURST without acking any requester.
  - The header is not counted in `r_count`.
- Undefined: the HDR state and its logic are absent; grant goes directly to BURST.

## Structure
- Package `tx_arb_pkg`:
  - state enum `tx_arb_state_t` (IDLE, HDR, BURST);
  - `TX_ARB_HDR_TAG` = 4'hA;
  - `TX_ARB_CNT_W` = 8.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and a pointer; outputs are the index and a found flag. It is parameterized by NUM_REQ.

## Test plan
- Single frame: req0 sends 0x11, 0x22, 0x33 (last on 0x33), with the transmitter dequeuing on each sample tick.
  - Line shows three frames: 0x11, 0x22, 0x33.
  - `o_req_ack[0]` pulses 3 times; `o_busy` falls after the third deq.
- Fairness: req0 and req2 hold 2-byte frames continuously.
  - Grants alternate 0, 2, 0, 2; bytes are never interleaved.
  - One IDLE cycle appears between grants.
- Burst cap with MAX_BURST=4: req1 sends 6 bytes with no `last`.
  - Release after 4 acks; req3, which is pending, is granted next.
  - req1 resumes afterwards with byte 5.
- Stall: granted req2 drops `valid` for 10 cycles mid-frame while req0 is valid.
  - `o_txq_empty`=1 and `o_grant_id`=2 held throughout; no ack to req0.
- Spurious deq: `i_deq_txq`=1 in IDLE and during the stall.
  - No ack, `r_count` unchanged.
- Reset: `i_rst_n` low after the 2nd byte of a frame.
  - `o_txq_empty`=1, `o_busy`=0, `o_grant_id`=0 immediately.
  - With `TX_ARB_HEADER_EN`, req3 frame 0x55 (last) produces bytes 0xA3 then 0x55, with exactly one ack to req3.
